// File: rtl/bram_sdp_be.sv
// Simple dual-port RAM: byte-lane writes on A, registered reads on B, zero-fill sweep after reset.
// Read latency 1 cycle (2 with BRAM_SDP_OUTREG_EN); no backpressure, port traffic dropped while busy.
`timescale 1ns/1ps
module bram_sdp_be #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clka,
  input  logic                    rstn,
  input  logic [ADDR_WIDTH-1:0]   addra,
  input  logic [DATA_WIDTH-1:0]   dina,
  input  logic [DATA_WIDTH/8-1:0] wea,
  input  logic [ADDR_WIDTH-1:0]   addrb,
  input  logic                    enb,
  output logic [DATA_WIDTH-1:0]   doutb,
  output logic                    validb,
  output logic                    busy
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if ((DATA_WIDTH % 8) != 0) begin : g_width_check
    $error("bram_sdp_be: DATA_WIDTH must be a multiple of 8");
  end

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rd_q, rd_d;
  logic                    rd_vld_q, rd_vld_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_rd;
  logic [DATA_WIDTH-1:0]   fwd_mask;
  logic                    ready;

  assign ready  = (state_q == READY);
  assign mem_rd = mem[addrb];
  assign busy   = !ready;

  // Lanes being written to the word being read this edge come from dina (write-first).
  always_comb begin
    fwd_mask = '0;
    if (addra == addrb) begin
      for (int i = 0; i < NB; i++) begin
        fwd_mask[8*i +: 8] = {8{wea[i]}};
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    rd_vld_d = 1'b0;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == '1) begin
          state_d = READY;
        end
      end
      default: begin
        if (enb) begin
          rd_d     = (mem_rd & ~fwd_mask) | (dina & fwd_mask);
          rd_vld_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      state_q  <= CLEAR;
      cnt_q    <= '0;
      rd_q     <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  // Array has no reset; the sweep owns the write port until READY.
  always_ff @(posedge clka) begin
    if (!ready) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wea[i]) begin
          mem[addra][8*i +: 8] <= dina[8*i +: 8];
        end
      end
    end
  end

`ifdef BRAM_SDP_OUTREG_EN
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  out_vld_q, out_vld_d;

  always_comb begin
    out_d     = out_q;
    out_vld_d = rd_vld_q;
    if (rd_vld_q) begin
      out_d = rd_q;
    end
  end

  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign doutb  = out_q;
  assign validb = out_vld_q;
`else
  assign doutb  = rd_q;
  assign validb = rd_vld_q;
`endif

endmodule

// File: tb/tb_bram_sdp_be.sv
// Randomised + directed bench for bram_sdp_be (ADDR_WIDTH=4) with a queue scoreboard and array model.
`timescale 1ns/1ps
module tb_bram_sdp_be;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** AW;
`ifdef BRAM_SDP_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk;
  logic          rstn;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic [NB-1:0] wea;
  logic [AW-1:0] addrb;
  logic          enb;
  logic [DW-1:0] doutb;
  logic          validb;
  logic          busy;

  bram_sdp_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clka  (clk),
    .rstn  (rstn),
    .addra (addra),
    .dina  (dina),
    .wea   (wea),
    .addrb (addrb),
    .enb   (enb),
    .doutb (doutb),
    .validb(validb),
    .busy  (busy)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [DW-1:0] ref_mem [DEPTH];
  int            sweep_left;
  int            cyc;
  int            errors;
  int            checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] lane_mask(input logic [NB-1:0] w);
    logic [DW-1:0] m;
    for (int i = 0; i < NB; i++) m[8*i +: 8] = {8{w[i]}};
    return m;
  endfunction

  // One clock: drive inputs, advance the reference model, step past the edge.
  task automatic cycle(input logic [AW-1:0] aa, input logic [DW-1:0] da, input logic [NB-1:0] wa,
                       input logic [AW-1:0] ab, input logic eb);
    logic [DW-1:0] m;
    logic [DW-1:0] rd;
    addra = aa; dina = da; wea = wa; addrb = ab; enb = eb;
    if (sweep_left > 0) begin
      sweep_left--;
    end else begin
      m = lane_mask(wa);
      if (eb) begin
        rd = ref_mem[ab];
        if (aa == ab) rd = (rd & ~m) | (da & m);
        exp_q.push_back('{data: rd, due: cyc + LAT});
      end
      ref_mem[aa] = (ref_mem[aa] & ~m) | (da & m);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("rst_doutb", doutb, 32'h0);
    chk("rst_validb", {31'b0, validb}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h1);
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    sweep_left = DEPTH;
    enb = 1'b0;
    wea = '0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Hammers random traffic during the sweep and measures how long busy stays up.
  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (busy && n < 4 * DEPTH) begin
      cycle(AW'($urandom_range(0, DEPTH - 1)), $urandom, NB'($urandom),
            AW'($urandom_range(0, DEPTH - 1)), 1'b1);
      n++;
    end
    chk(name, n, DEPTH);
    enb = 1'b0;
    wea = '0;
  endtask

  always @(negedge clk) begin
    if (validb) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got validb=1 doutb=%h expected no read (cycle %0d)", doutb, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rd_data", doutb, mon_e.data);
        chk("rd_latency", cyc, mon_e.due);
      end
    end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_valid: got validb=0 expected data %h at cycle %0d", exp_q[0].data, exp_q[0].due);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end of test by 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    rstn = 1'b0;
    addra = '0; dina = '0; wea = '0; addrb = '0; enb = 1'b0;
    sweep_left = DEPTH;
    #12;
    do_reset();
    count_busy("sweep_len_initial");
    chk("busy_low_after_sweep", {31'b0, busy}, 32'h0);

    // Leave garbage at addr 5, reset while the read result is on doutb, expect it cleared.
    cycle(4'd5, 32'hDEADBEEF, 4'hF, '0, 1'b0);
    cycle('0, '0, '0, 4'd5, 1'b1);
    idle(LAT);
    do_reset();
    count_busy("sweep_len_after_op_reset");
    cycle('0, '0, '0, 4'd5, 1'b1);
    idle(2);

    cycle(4'd3, 32'h11223344, 4'hF, '0, 1'b0);
    cycle(4'd3, 32'hAABBCCDD, 4'b0101, '0, 1'b0);
    cycle('0, '0, '0, 4'd3, 1'b1);
    idle(2);

    cycle(4'd7, 32'h01020304, 4'hF, '0, 1'b0);
    cycle(4'd7, 32'hFF000000, 4'b1000, 4'd7, 1'b1);
    cycle('0, '0, '0, 4'd7, 1'b1);
    idle(2);

    for (int i = 0; i < 4; i++) cycle(AW'(i), DW'(32'h10 + i), 4'hF, '0, 1'b0);
    for (int i = 0; i < 4; i++) cycle('0, '0, '0, AW'(i), 1'b1);
    idle(2);

    for (int k = 0; k < 300; k++) begin
      logic [AW-1:0] aa;
      aa = AW'($urandom_range(0, DEPTH - 1));
      cycle(aa, $urandom, NB'($urandom),
            ($urandom_range(0, 3) == 0) ? aa : AW'($urandom_range(0, DEPTH - 1)),
            $urandom_range(0, 3) != 0);
    end
    idle(3);

    // Reset in the middle of the sweep must restart it from scratch.
    do_reset();
    for (int i = 0; i < 8; i++) cycle('0, '0, '0, AW'(i), 1'b1);
    do_reset();
    count_busy("sweep_len_after_midsweep_reset");
    cycle('0, '0, '0, 4'd9, 1'b1);
    idle(4);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
